// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares the single main-memory port between the
// instruction-cache refill path and the data-cache path.
// Fixed priority (dc write > dc read > ic) with an instruction-cache
// starvation guard. Optional bus watchdog enabled by `SEGRE_ARB_TIMEOUT_EN.
module segre_mem_arbiter #(
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned LINE_BYTES     = 16,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    ic_req_i,
  input  logic [ADDR_SIZE-1:0]    ic_addr_i,
  output logic                    ic_ready_o,
  input  logic                    dc_rd_i,
  input  logic                    dc_wr_i,
  input  logic [ADDR_SIZE-1:0]    dc_addr_i,
  input  logic [1:0]              dc_type_i,
  input  logic [LINE_BYTES*8-1:0] dc_line_i,
  output logic                    dc_ready_o,
  output logic                    mem_rd_o,
  output logic                    mem_wr_o,
  output logic [ADDR_SIZE-1:0]    mem_addr_o,
  output logic [1:0]              mem_type_o,
  output logic [LINE_BYTES*8-1:0] mem_line_o,
  input  logic                    mem_ready_i,
  input  logic [LINE_BYTES*8-1:0] mem_line_i,
  output logic [LINE_BYTES*8-1:0] line_o,
  output logic                    busy_o,
  output logic [1:0]              owner_o,
  output logic                    err_o
);

  localparam int unsigned LW = LINE_BYTES * 8;

  localparam logic [1:0] TYPE_WORD = 2'b10;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IC   = 2'b01;
  localparam logic [1:0] OWN_DRD  = 2'b10;
  localparam logic [1:0] OWN_DWR  = 2'b11;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Elaboration-time parameter range checks
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("segre_mem_arbiter: STARVE_LIMIT must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("segre_mem_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             owner_q, owner_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [1:0]             type_q, type_d;
  logic [LW-1:0]          mline_q, mline_d;
  logic [LW-1:0]          line_q, line_d;
  logic [3:0]             starve_q, starve_d;

`ifdef SEGRE_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]             wd_q, wd_d;
  logic                   err_q, err_d;
`endif

  // Next-state and datapath selection for the IDLE -> BUSY -> RESP cycle
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    addr_d   = addr_q;
    type_d   = type_q;
    mline_d  = mline_q;
    line_d   = line_q;
    starve_d = starve_q;
`ifdef SEGRE_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (ic_req_i && (starve_q == STARVE_MAX)) begin
          state_d  = S_BUSY;
          owner_d  = OWN_IC;
          mem_rd_d = 1'b1;
          addr_d   = ic_addr_i;
          type_d   = TYPE_WORD;
          mline_d  = '0;
          starve_d = '0;
        end else if (dc_wr_i || dc_rd_i) begin
          state_d  = S_BUSY;
          owner_d  = dc_wr_i ? OWN_DWR : OWN_DRD;
          mem_wr_d = dc_wr_i;
          mem_rd_d = ~dc_wr_i;
          addr_d   = dc_addr_i;
          type_d   = dc_type_i;
          mline_d  = dc_line_i;
          if (ic_req_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (ic_req_i) begin
          state_d  = S_BUSY;
          owner_d  = OWN_IC;
          mem_rd_d = 1'b1;
          addr_d   = ic_addr_i;
          type_d   = TYPE_WORD;
          mline_d  = '0;
          starve_d = '0;
        end
`ifdef SEGRE_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
      end

      S_BUSY: begin
        if (mem_ready_i) begin
          if (mem_rd_q) begin
            line_d = mem_line_i;
          end
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = S_RESP;
        end
`ifdef SEGRE_ARB_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          // Abandon the transaction silently: no ready pulse is issued
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          owner_d  = OWN_NONE;
          state_d  = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end

      S_RESP: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end

      default: begin
        owner_d  = OWN_NONE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset abandons any in-flight access
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      type_q   <= '0;
      mline_q  <= '0;
      line_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      addr_q   <= addr_d;
      type_q   <= type_d;
      mline_q  <= mline_d;
      line_q   <= line_d;
      starve_q <= starve_d;
    end
  end

`ifdef SEGRE_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ic_ready_o = (state_q == S_RESP) && (owner_q == OWN_IC);
  assign dc_ready_o = (state_q == S_RESP) && owner_q[1];
  assign mem_rd_o   = mem_rd_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = addr_q;
  assign mem_type_o = type_q;
  assign mem_line_o = mline_q;
  assign line_o     = line_q;
  assign busy_o     = (state_q != S_IDLE);
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed self-checking bench for segre_mem_arbiter.
module tb_segre_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk_i = 1'b0;
  logic          rsn_i = 1'b1;
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_ready_o;
  logic          dc_rd_i = 1'b0;
  logic          dc_wr_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [1:0]    dc_type_i = '0;
  logic [LW-1:0] dc_line_i = '0;
  logic          dc_ready_o;
  logic          mem_rd_o;
  logic          mem_wr_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    mem_type_o;
  logic [LW-1:0] mem_line_o;
  logic          mem_ready_i = 1'b0;
  logic [LW-1:0] mem_line_i = '0;
  logic [LW-1:0] line_o;
  logic          busy_o;
  logic [1:0]    owner_o;
  logic          err_o;

  int vectors = 0;
  int miscompares = 0;

  segre_mem_arbiter #(
    .ADDR_SIZE(AW),
    .LINE_BYTES(16),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ready_o(ic_ready_o),
    .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i), .dc_addr_i(dc_addr_i),
    .dc_type_i(dc_type_i), .dc_line_i(dc_line_i), .dc_ready_o(dc_ready_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_type_o(mem_type_o), .mem_line_o(mem_line_o),
    .mem_ready_i(mem_ready_i), .mem_line_i(mem_line_i),
    .line_o(line_o), .busy_o(busy_o), .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({mem_rd_o, mem_wr_o, ic_ready_o, dc_ready_o, busy_o, err_o, owner_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {mem_rd_o, mem_wr_o, ic_ready_o, dc_ready_o, busy_o, err_o, owner_o});
    end
    vectors++;
    if (mem_addr_o !== '0 || mem_type_o !== 2'b00 || mem_line_o !== '0 || line_o !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h type=%b mline=%h line=%h expected all 0",
               mem_addr_o, mem_type_o, mem_line_o, line_o);
    end
    rsn_i = 1'b0;
    step();
  endtask

  task automatic test_ic_read();
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_0040;
    step();
    vectors++;
    if ({mem_rd_o, mem_wr_o, owner_o, mem_type_o, busy_o} !== 7'b1_0_01_10_1 || mem_addr_o !== 32'h40) begin
      miscompares++;
      $display("FAIL ic_cmd: rd/wr/own/type/busy=%b addr=%h expected 1001101 addr=00000040",
               {mem_rd_o, mem_wr_o, owner_o, mem_type_o, busy_o}, mem_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h40 || ic_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL ic_hold%0d: rd=%b addr=%h rdy=%b expected 1 00000040 0",
                 k, mem_rd_o, mem_addr_o, ic_ready_o);
      end
    end
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'hA5}};
    step();
    mem_ready_i = 1'b0;
    mem_line_i  = '0;
    vectors++;
    if ({ic_ready_o, dc_ready_o, mem_rd_o, owner_o} !== 5'b1_0_0_01 || line_o !== {16{8'hA5}}) begin
      miscompares++;
      $display("FAIL ic_resp: icr/dcr/rd/own=%b line=%h expected 10001 line=a5..a5",
               {ic_ready_o, dc_ready_o, mem_rd_o, owner_o}, line_o);
    end
    ic_req_i = 1'b0;
    step();
    vectors++;
    if ({ic_ready_o, busy_o, owner_o} !== 4'b0000 || line_o !== {16{8'hA5}}) begin
      miscompares++;
      $display("FAIL ic_done: icr/busy/own=%b line=%h expected 0000 line=a5..a5",
               {ic_ready_o, busy_o, owner_o}, line_o);
    end
  endtask

  task automatic test_priority();
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_1000;
    dc_wr_i   = 1'b1;
    dc_rd_i   = 1'b1;
    dc_addr_i = 32'h0000_0100;
    dc_type_i = 2'b01;
    dc_line_i = {8{16'h1111}};
    step();
    vectors++;
    if ({owner_o, mem_wr_o, mem_rd_o, mem_type_o} !== 6'b11_1_0_01 || mem_line_o !== {8{16'h1111}}
        || mem_addr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL prio_wr: own/wr/rd/type=%b addr=%h mline=%h expected 111001 00000100 1111..",
               {owner_o, mem_wr_o, mem_rd_o, mem_type_o}, mem_addr_o, mem_line_o);
    end
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'hEE}};
    step();
    mem_ready_i = 1'b0;
    vectors++;
    if ({dc_ready_o, ic_ready_o, owner_o} !== 4'b1011 || line_o !== {16{8'hA5}}) begin
      miscompares++;
      $display("FAIL prio_wr_resp: dcr/icr/own=%b line=%h expected 1011 line=a5..a5 (write keeps line)",
               {dc_ready_o, ic_ready_o, owner_o}, line_o);
    end
    dc_wr_i = 1'b0;
    step();
    vectors++;
    if ({dc_ready_o, busy_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL prio_wr_once: dcr/busy=%b expected 00", {dc_ready_o, busy_o});
    end
    dc_addr_i = 32'h0000_0200;
    step();
    vectors++;
    if ({owner_o, mem_rd_o, mem_wr_o} !== 4'b10_1_0 || mem_addr_o !== 32'h200) begin
      miscompares++;
      $display("FAIL prio_rd: own/rd/wr=%b addr=%h expected 1010 00000200",
               {owner_o, mem_rd_o, mem_wr_o}, mem_addr_o);
    end
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'h5A}};
    step();
    mem_ready_i = 1'b0;
    vectors++;
    if ({dc_ready_o, ic_ready_o} !== 2'b10 || line_o !== {16{8'h5A}}) begin
      miscompares++;
      $display("FAIL prio_rd_resp: dcr/icr=%b line=%h expected 10 5a..5a", {dc_ready_o, ic_ready_o}, line_o);
    end
    dc_rd_i = 1'b0;
    step();
    step();
    vectors++;
    if ({owner_o, mem_rd_o, mem_type_o} !== 5'b01_1_10 || mem_addr_o !== 32'h1000 || mem_line_o !== '0) begin
      miscompares++;
      $display("FAIL prio_ic: own/rd/type=%b addr=%h mline=%h expected 01110 00001000 0",
               {owner_o, mem_rd_o, mem_type_o}, mem_addr_o, mem_line_o);
    end
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'h33}};
    step();
    mem_ready_i = 1'b0;
    vectors++;
    if ({ic_ready_o, dc_ready_o} !== 2'b10 || line_o !== {16{8'h33}}) begin
      miscompares++;
      $display("FAIL prio_ic_resp: icr/dcr=%b line=%h expected 10 33..33", {ic_ready_o, dc_ready_o}, line_o);
    end
    ic_req_i = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_own;
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_2000;
    dc_rd_i   = 1'b1;
    dc_addr_i = 32'h0000_3000;
    dc_type_i = 2'b10;
    for (int g = 0; g < 6; g++) begin
      exp_own = (g == 4) ? 2'b01 : 2'b10;
      step();
      vectors++;
      if (owner_o !== exp_own || mem_rd_o !== 1'b1) begin
        miscompares++;
        $display("FAIL starve_grant%0d: own=%b rd=%b expected %b 1", g, owner_o, mem_rd_o, exp_own);
      end
      mem_ready_i = 1'b1;
      step();
      mem_ready_i = 1'b0;
      vectors++;
      if ({ic_ready_o, dc_ready_o} !== ((g == 4) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL starve_ready%0d: icr/dcr=%b expected %b", g, {ic_ready_o, dc_ready_o},
                 (g == 4) ? 2'b10 : 2'b01);
      end
      step();
    end
    ic_req_i = 1'b0;
    dc_rd_i  = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_0080;
    step();
    vectors++;
    if (busy_o !== 1'b1 || mem_rd_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: busy=%b rd=%b expected 1 1", busy_o, mem_rd_o);
    end
    #2 rsn_i = 1'b1;
    ic_req_i = 1'b0;
    #1;
    vectors++;
    if ({mem_rd_o, mem_wr_o, busy_o, owner_o, ic_ready_o} !== 6'b0 || mem_addr_o !== '0 || line_o !== '0) begin
      miscompares++;
      $display("FAIL rst_async: rd/wr/busy/own/icr=%b addr=%h line=%h expected all 0",
               {mem_rd_o, mem_wr_o, busy_o, owner_o, ic_ready_o}, mem_addr_o, line_o);
    end
    #2 rsn_i = 1'b0;
    step();
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'h77}};
    step();
    mem_ready_i = 1'b0;
    step();
    vectors++;
    if ({ic_ready_o, dc_ready_o, busy_o} !== 3'b000 || line_o !== '0) begin
      miscompares++;
      $display("FAIL rst_late_ready: icr/dcr/busy=%b line=%h expected 000 0",
               {ic_ready_o, dc_ready_o, busy_o}, line_o);
    end
    dc_rd_i   = 1'b1;
    dc_addr_i = 32'h0000_0400;
    step();
    vectors++;
    if ({owner_o, mem_rd_o} !== 3'b10_1 || mem_addr_o !== 32'h400) begin
      miscompares++;
      $display("FAIL rst_regrant: own/rd=%b addr=%h expected 101 00000400", {owner_o, mem_rd_o}, mem_addr_o);
    end
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'h3C}};
    step();
    mem_ready_i = 1'b0;
    dc_rd_i = 1'b0;
    step();
  endtask

  task automatic test_spurious();
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'hFF}};
    step();
    mem_ready_i = 1'b0;
    vectors++;
    if ({busy_o, ic_ready_o, dc_ready_o, mem_rd_o} !== 4'b0000 || line_o !== {16{8'h3C}}) begin
      miscompares++;
      $display("FAIL spur_idle: busy/icr/dcr/rd=%b line=%h expected 0000 3c..3c",
               {busy_o, ic_ready_o, dc_ready_o, mem_rd_o}, line_o);
    end
    dc_rd_i   = 1'b1;
    dc_addr_i = 32'h0000_0500;
    step();
    mem_ready_i = 1'b1;
    mem_line_i  = {16{8'h12}};
    step();
    mem_line_i = {16{8'h99}};
    dc_rd_i    = 1'b0;
    step();
    mem_ready_i = 1'b0;
    vectors++;
    if ({busy_o, dc_ready_o, ic_ready_o} !== 3'b000 || line_o !== {16{8'h12}}) begin
      miscompares++;
      $display("FAIL spur_resp: busy/dcr/icr=%b line=%h expected 000 12..12",
               {busy_o, dc_ready_o, ic_ready_o}, line_o);
    end
    step();
    vectors++;
    if ({busy_o, dc_ready_o, mem_rd_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL spur_after: busy/dcr/rd=%b expected 000", {busy_o, dc_ready_o, mem_rd_o});
    end
  endtask

`ifdef SEGRE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_0600;
    step();
    for (int k = 0; k < 9; k++) begin
      step();
      vectors++;
      if ({busy_o, err_o, mem_rd_o} !== 3'b101) begin
        miscompares++;
        $display("FAIL wd_wait%0d: busy/err/rd=%b expected 101", k, {busy_o, err_o, mem_rd_o});
      end
    end
    step();
    vectors++;
    if ({err_o, mem_rd_o, busy_o, ic_ready_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wd_fire: err/rd/busy/icr=%b expected 1000", {err_o, mem_rd_o, busy_o, ic_ready_o});
    end
    ic_req_i = 1'b0;
    dc_rd_i  = 1'b1;
    step();
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    dc_rd_i = 1'b0;
    vectors++;
    if ({dc_ready_o, err_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL wd_sticky: dcr/err=%b expected 11", {dc_ready_o, err_o});
    end
    step();
    rsn_i = 1'b1;
    #1;
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_clear: err=%b expected 0", err_o);
    end
    rsn_i = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_ic_read();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_spurious();
`ifdef SEGRE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache path (line reads, writebacks and write-throughs).
- Sits between the fetch/MEM stages and main memory.
- Grants one requester at a time and holds the memory command stable until memory answers.
- Returns the refilled line and a one-cycle ready pulse to the owner.
- Fixed priority (data-cache write, then data-cache read, then instruction-cache) with a starvation guard for the instruction cache.

Parameters:
- ADDR_SIZE, 32, address width.
- LINE_BYTES, 16, cache line size in bytes; line buses are LINE_BYTES*8 bits.
- STARVE_LIMIT, 4, number of consecutive data-cache grants allowed while ic_req_i is pending before the instruction cache is forced. Legal range 1..15.
- TIMEOUT_CYCLES, 255, watchdog limit used only with SEGRE_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset; asynchronous, active-high
- ic_req_i  in  1  instruction-cache line read request; level, held until ic_ready_o
- ic_addr_i  in  ADDR_SIZE  instruction-cache request address
- ic_ready_o  out  1  one-cycle pulse; line_o is valid for the instruction cache
- dc_rd_i  in  1  data-cache line read request; level
- dc_wr_i  in  1  data-cache write/writeback request; level
- dc_addr_i  in  ADDR_SIZE  data-cache request address
- dc_type_i  in  2  memop data type (BYTE/HALF/WORD)
- dc_line_i  in  LINE_BYTES*8  data-cache write data
- dc_ready_o  out  1  one-cycle pulse; data-cache transaction complete
- mem_rd_o  out  1  memory read command
- mem_wr_o  out  1  memory write command
- mem_addr_o  out  ADDR_SIZE  memory address
- mem_type_o  out  2  memory data type; WORD for instruction-cache requests
- mem_line_o  out  LINE_BYTES*8  memory write data
- mem_ready_i  in  1  memory completion pulse
- mem_line_i  in  LINE_BYTES*8  memory read data
- line_o  out  LINE_BYTES*8  registered return line
- busy_o  out  1  state is not IDLE
- owner_o  out  2  00 none, 01 instruction cache, 10 data-cache read, 11 data-cache write
- err_o  out  1  watchdog error; sticky

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state = IDLE, owner_o = 00.
  - mem_rd_o, mem_wr_o, ic_ready_o, dc_ready_o, busy_o, err_o = 0.
  - mem_addr_o, mem_type_o, mem_line_o, line_o = 0.
  - Starvation counter = 0.
  - An in-flight memory transaction is abandoned; mem_ready_i arriving after reset is ignored.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE, at each edge with any request pending, choose in this order:
  - ic_req_i pending and counter == STARVE_LIMIT: grant the instruction cache.
  - Else dc_wr_i: grant data-cache write. If dc_rd_i and dc_wr_i are both high, the write wins.
  - Else dc_rd_i: grant data-cache read.
  - Else ic_req_i: grant the instruction cache.
- On grant:
  - Register owner, mem_addr_o, mem_type_o and mem_line_o (instruction cache: line = 0).
  - Assert exactly one of mem_rd_o / mem_wr_o; state -> BUSY.
  - Latency: request sampled at edge N gives the command visible from cycle N+1.
- Starvation counter:
  - Increments on each data-cache grant made while ic_req_i = 1.
  - Clears on an instruction-cache grant.
  - Saturates at STARVE_LIMIT.
- BUSY:
  - Command outputs are held constant.
  - On mem_ready_i = 1: line_o <= mem_line_i (reads only; writes leave line_o unchanged), mem_rd_o/mem_wr_o <= 0, state -> RESP.
- RESP:
  - The owner's ready_o = 1 for exactly this cycle; owner_o is still valid.
  - No grant is made in RESP, so a requester dropping its request in the next cycle is never regranted.
  - State -> IDLE.
  - Best-case back-to-back throughput: one transaction per 3 cycles plus memory latency.
- mem_ready_i in IDLE or RESP: ignored.
- A requester deasserting before its ready pulse is a protocol violation; the arbiter completes the transaction anyway.
- busy_o = (state != IDLE).
- ic_ready_o and dc_ready_o are never high in the same cycle.

Optional Feature:
- Macro: SEGRE_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog counts cycles in BUSY and clears on entry to BUSY.
  - On reaching TIMEOUT_CYCLES without mem_ready_i: err_o <= 1 (sticky until reset), commands drop, state -> IDLE, no ready pulse is issued.
- When undefined:
  - No watchdog logic; err_o is tied 0.
  - BUSY waits indefinitely for mem_ready_i.

Test Plan:
1. Single instruction-cache read: ic_req_i = 1, addr 0x0000_0040; memory answers 5 cycles after the command with line 0xA5..A5 -> mem_rd_o = 1 from the cycle after the request, mem_addr_o = 0x40, mem_type_o = WORD; ic_ready_o pulses 1 cycle after mem_ready_i; line_o = 0xA5..A5; owner_o = 01.
2. Simultaneous dc_wr_i, dc_rd_i and ic_req_i in IDLE -> grant order: write (owner 11, mem_wr_o = 1, mem_line_o = dc_line_i), then read (10), then instruction cache (01); each transaction has exactly one ready pulse.
3. Starvation with STARVE_LIMIT = 4: ic_req_i held high, dc_rd_i re-requested continuously -> exactly 4 data-cache grants, then an instruction-cache grant; counter returns to 0.
4. Reset mid-transaction: rsn_i pulsed high while BUSY, then mem_ready_i arrives -> all outputs 0 immediately; no ready pulse; next request is granted normally.
5. Spurious mem_ready_i in IDLE and RESP -> no state change; line_o unchanged; no extra ready pulse.
6. With SEGRE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 10, memory never answers -> err_o = 1 after 10 BUSY cycles; mem_rd_o = 0; state IDLE; err_o stays 1 across later transactions until reset.
